arith_selftest: RTL and testbench

// Self-checking arithmetic test harness. Drives a fixed vector table into three

---
 rtl/arith_selftest.sv | 141 ++++++++++++++
 tb/tb_arith_selftest.sv | 116 +++++++++++
 2 files changed

// File: rtl/arith_selftest.sv
// Purpose : built-in arithmetic self-test; walks a fixed 8-entry vector table through
//           scalar add, 4-lane vector add and multiply-add, checks against golden values.
// Latency : results registered 1 cycle after issue, compared the following cycle; finish after edge NUM_VEC+1.
// Backpressure: none; free-running after reset release, outputs freeze once finish is set.
// Ports   : clock (rising edge), reset (async, active-high),
//           fail (sticky mismatch seen), finish (sticky all vectors compared).
module arith_selftest #(
    parameter int NUM_VEC      = 8,
    parameter bit INJECT_ERROR = 1'b0
) (
    input  logic clock,
    input  logic reset,
    output logic fail,
    output logic finish
);
    localparam logic [3:0] NV   = 4'(NUM_VEC);
    localparam logic [3:0] LAST = 4'(NUM_VEC - 1);

    function automatic logic [7:0] tab_a(input logic [2:0] i);
        case (i)
            3'd0: tab_a = 8'd0;   3'd1: tab_a = 8'd1;
            3'd2: tab_a = 8'd127; 3'd3: tab_a = 8'd128;
            3'd4: tab_a = 8'd255; 3'd5: tab_a = 8'd200;
            3'd6: tab_a = 8'd3;   default: tab_a = 8'd100;
        endcase
    endfunction

    function automatic logic [7:0] tab_b(input logic [2:0] i);
        case (i)
            3'd0: tab_b = 8'd0;   3'd1: tab_b = 8'd1;
            3'd2: tab_b = 8'd1;   3'd3: tab_b = 8'd128;
            3'd4: tab_b = 8'd1;   3'd5: tab_b = 8'd100;
            3'd6: tab_b = 8'd4;   default: tab_b = 8'd155;
        endcase
    endfunction

    function automatic logic [7:0] gold_add(input logic [2:0] i);
        case (i)
            3'd0: gold_add = 8'd0;   3'd1: gold_add = 8'd2;
            3'd2: gold_add = 8'd128; 3'd3: gold_add = 8'd0;
            3'd4: gold_add = 8'd0;   3'd5: gold_add = 8'd44;
            3'd6: gold_add = 8'd7;   default: gold_add = 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] gold_mac(input logic [2:0] i);
        case (i)
            3'd0: gold_mac = 8'd0;   3'd1: gold_mac = 8'd2;
            3'd2: gold_mac = 8'd129; 3'd3: gold_mac = 8'd3;
            3'd4: gold_mac = 8'd3;   3'd5: gold_mac = 8'd37;
            3'd6: gold_mac = 8'd18;  default: gold_mac = 8'd147;
        endcase
    endfunction

    logic [3:0]  idx_q, idx_d;
    logic [3:0]  check_idx_q, check_idx_d;
    logic        check_valid_q, check_valid_d;
    logic [7:0]  s_add_q, s_add_d;
    logic [31:0] v_add_q, v_add_d;
    logic [7:0]  s_mac_q, s_mac_d;
    logic        fail_q, fail_d;
    logic        finish_q, finish_d;

    logic        advance;
    logic        mismatch;
    logic [7:0]  s_add;
    logic [31:0] v_add;
    logic [7:0]  s_mac;
    logic [15:0] mac_full;
    logic [2:0]  vi;
    logic [2:0]  li;
    logic [2:0]  ci;
    logic [2:0]  gi;

    // Datapaths, combinational from idx; everything wraps mod 256.
    always_comb begin
        vi       = idx_q[2:0];
        li       = 3'd0;
        s_add    = tab_a(vi) + tab_b(vi);
        if (INJECT_ERROR && idx_q == 4'd3) begin
            s_add[0] = ~s_add[0];
        end
        v_add    = 32'd0;
        for (int k = 0; k < 4; k++) begin
            li                = vi + 3'(k);     // 3-bit wrap gives the %8 lane index
            v_add[8*k +: 8]   = tab_a(li) + tab_b(li);
        end
        mac_full = {8'd0, tab_a(vi)} * {8'd0, tab_b(vi)} + {13'd0, vi};
        s_mac    = mac_full[7:0];
    end

    always_comb begin
        advance       = (idx_q < NV) && !finish_q;
        ci            = check_idx_q[2:0];
        gi            = 3'd0;

        mismatch = (s_add_q != gold_add(ci)) || (s_mac_q != gold_mac(ci));
        for (int k = 0; k < 4; k++) begin
            gi = ci + 3'(k);
            if (v_add_q[8*k +: 8] != gold_add(gi)) begin
                mismatch = 1'b1;
            end
        end
        mismatch = mismatch && check_valid_q;

        idx_d         = advance ? idx_q + 4'd1 : idx_q;
        check_idx_d   = advance ? idx_q : check_idx_q;
        // Issue stops once idx reaches NUM_VEC, so the last compare also drops valid.
        check_valid_d = advance;
        s_add_d       = advance ? s_add : s_add_q;
        v_add_d       = advance ? v_add : v_add_q;
        s_mac_d       = advance ? s_mac : s_mac_q;
        fail_d        = fail_q | mismatch;
        finish_d      = finish_q | (check_valid_q && check_idx_q == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q         <= 4'd0;
            check_idx_q   <= 4'd0;
            check_valid_q <= 1'b0;
            s_add_q       <= 8'd0;
            v_add_q       <= 32'd0;
            s_mac_q       <= 8'd0;
            fail_q        <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            check_idx_q   <= check_idx_d;
            check_valid_q <= check_valid_d;
            s_add_q       <= s_add_d;
            v_add_q       <= v_add_d;
            s_mac_q       <= s_mac_d;
            fail_q        <= fail_d;
            finish_q      <= finish_d;
        end
    end

    assign fail   = fail_q;
    assign finish = finish_q;
endmodule

// File: tb/tb_arith_selftest.sv
module tb_arith_selftest;
    logic clk;
    logic rst;
    logic fail0, finish0, fail1, finish1;

    arith_selftest #(.NUM_VEC(8), .INJECT_ERROR(1'b0)) dut0 (
        .clock(clk), .reset(rst), .fail(fail0), .finish(finish0)
    );
    arith_selftest #(.NUM_VEC(8), .INJECT_ERROR(1'b1)) dut1 (
        .clock(clk), .reset(rst), .fail(fail1), .finish(finish1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f0, fin0, f1, fin1, cv;
        logic [7:0]  sa;
        logic [31:0] va;
        logic [7:0]  sm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   e     = 0;     // edges seen with reset low since the last reset

    int a_tab[8] = '{0, 1, 127, 128, 255, 200, 3, 100};
    int b_tab[8] = '{0, 1, 1, 128, 1, 100, 4, 155};

    // Reference: outputs depend only on how many edges have run since reset release.
    function automatic exp_t model(input int edges, input logic in_rst);
        exp_t x;
        int   v;
        int   j;
        x.f0 = 0; x.fin0 = 0; x.f1 = 0; x.fin1 = 0; x.cv = 0;
        x.sa = 0; x.va = 0; x.sm = 0;
        if (!in_rst && edges > 0) begin
            x.fin0 = (edges >= 9);
            x.fin1 = (edges >= 9);
            x.f1   = (edges >= 5);
            x.cv   = (edges <= 8);
            v      = (edges - 1 > 7) ? 7 : edges - 1;
            x.sa   = 8'((a_tab[v] + b_tab[v]) % 256);
            x.sm   = 8'((a_tab[v] * b_tab[v] + v) % 256);
            for (int k = 0; k < 4; k++) begin
                j = (v + k) % 8;
                x.va[8*k +: 8] = 8'((a_tab[j] + b_tab[j]) % 256);
            end
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("fail0",       32'(fail0),   32'(x.f0));
            chk("finish0",     32'(finish0), 32'(x.fin0));
            chk("fail1_inj",   32'(fail1),   32'(x.f1));
            chk("finish1_inj", 32'(finish1), 32'(x.fin1));
            chk("check_valid", 32'(dut0.check_valid_q), 32'(x.cv));
            chk("s_add",       32'(dut0.s_add_q), 32'(x.sa));
            chk("v_add",       dut0.v_add_q,      x.va);
            chk("s_mac",       32'(dut0.s_mac_q), 32'(x.sm));
        end
    end

    // One clock: account for the edge, then optionally change reset, then post expectation.
    task automatic cycle(input logic r);
        @(posedge clk);
        if (rst) e = 0; else e = e + 1;
        #1;
        rst = r;
        if (r) e = 0;
        sb.push_back(model(e, rst));
    endtask

    task automatic seg(input logic r, input int n);
        for (int i = 0; i < n; i++) cycle(r);
    endtask

    initial begin
        rst = 1'b1;
        // Long reset, full run plus 20+ idle cycles past finish.
        seg(1'b1, 16);
        seg(1'b0, 30);
        // Reset asserted right after the 4th edge for 2 cycles, then a full rerun.
        seg(1'b1, 2);
        seg(1'b0, 4);
        seg(1'b1, 2);
        seg(1'b0, 12);
        // Randomised reset placement and duration.
        for (int r = 0; r < 6; r++) begin
            seg(1'b1, int'($urandom_range(1, 3)));
            seg(1'b0, int'($urandom_range(2, 14)));
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
